// File: rtl/obi_master_adapter_if.sv
// obi_master_adapter_if: word request and read response streams between the serializer and the OBI adapter.
interface VX_mem_req_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 1
);
    logic                  valid;
    logic                  ready;
    logic                  rw;
    logic [3:0]            byteen;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [TAG_WIDTH-1:0]  tag;

    modport master (output valid, rw, byteen, addr, data, tag, input ready);
    modport slave  (input valid, rw, byteen, addr, data, tag, output ready);
endinterface

interface VX_mem_rsp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 1
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [TAG_WIDTH-1:0]  tag;

    modport master (output valid, data, tag, input ready);
    modport slave  (input valid, data, tag, output ready);
endinterface

// File: rtl/obi_master_adapter.sv
// obi_master_adapter: credit-limited OBI master that returns tagged read data and retires writes silently.
module obi_master_adapter #(
    parameter int ADDR_WIDTH_BIT  = 32,
    parameter int DATA_WIDTH_BIT  = 32,
    parameter int TAG_WIDTH_BIT   = 1,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    VX_mem_req_if.slave               in_mem_req,
    VX_mem_rsp_if.master              in_mem_rsp,
    output logic                      obi_req_o,
    input  logic                      obi_gnt_i,
    output logic [ADDR_WIDTH_BIT-1:0] obi_addr_o,
    output logic                      obi_we_o,
    output logic [3:0]                obi_be_o,
    output logic [DATA_WIDTH_BIT-1:0] obi_wdata_o,
    input  logic                      obi_rvalid_i,
    input  logic [DATA_WIDTH_BIT-1:0] obi_rdata_i,
    output logic                      protocol_err_o
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int IW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [IW-1:0] LAST = IW'(MAX_OUTSTANDING - 1);
    localparam logic [CW-1:0] MAX = CW'(MAX_OUTSTANDING);

    typedef struct packed {
        logic                     rw;
        logic [TAG_WIDTH_BIT-1:0] tag;
    } tag_ent_t;

    typedef struct packed {
        logic [DATA_WIDTH_BIT-1:0] data;
        logic [TAG_WIDTH_BIT-1:0]  tag;
    } rsp_ent_t;

    logic [CW-1:0] pending, tag_cnt, rsp_cnt;
    logic [IW-1:0] tag_wp, tag_rp, rsp_wp, rsp_rp;
    tag_ent_t      tag_mem [MAX_OUTSTANDING];
    rsp_ent_t      rsp_mem [MAX_OUTSTANDING];
    tag_ent_t      head;
    logic          credit_ok, gnt_hs, rv_ok, rsp_push, wr_ret, rsp_hs;

    function automatic logic [IW-1:0] nxt(input logic [IW-1:0] p);
        return p == LAST ? '0 : p + IW'(1);
    endfunction

    assign credit_ok        = pending < MAX;
    assign obi_req_o        = in_mem_req.valid && credit_ok;
    assign in_mem_req.ready = obi_gnt_i && credit_ok;
    assign obi_addr_o       = in_mem_req.addr;
    assign obi_we_o         = in_mem_req.rw;
    assign obi_be_o         = in_mem_req.byteen;
    assign obi_wdata_o      = in_mem_req.data;
    assign gnt_hs           = obi_req_o && obi_gnt_i;

    // An rvalid with nothing tracked is ignored; it only raises the error flag.
    assign head     = tag_mem[tag_rp];
    assign rv_ok    = obi_rvalid_i && tag_cnt != '0;
    assign rsp_push = rv_ok && !head.rw;
    assign wr_ret   = rv_ok && head.rw;

    assign in_mem_rsp.valid = rsp_cnt != '0;
    assign in_mem_rsp.data  = rsp_mem[rsp_rp].data;
    assign in_mem_rsp.tag   = rsp_mem[rsp_rp].tag;
    assign rsp_hs           = in_mem_rsp.valid && in_mem_rsp.ready;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending        <= '0;
            tag_cnt        <= '0;
            rsp_cnt        <= '0;
            tag_wp         <= '0;
            tag_rp         <= '0;
            rsp_wp         <= '0;
            rsp_rp         <= '0;
            protocol_err_o <= 1'b0;
        end else begin
            pending <= pending + CW'(gnt_hs) - CW'(wr_ret) - CW'(rsp_hs);
            tag_cnt <= tag_cnt + CW'(gnt_hs) - CW'(rv_ok);
            rsp_cnt <= rsp_cnt + CW'(rsp_push) - CW'(rsp_hs);
            if (gnt_hs) tag_wp <= nxt(tag_wp);
            if (rv_ok) tag_rp <= nxt(tag_rp);
            if (rsp_push) rsp_wp <= nxt(rsp_wp);
            if (rsp_hs) rsp_rp <= nxt(rsp_rp);
            if (obi_rvalid_i && tag_cnt == '0) protocol_err_o <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (gnt_hs) tag_mem[tag_wp] <= '{rw: in_mem_req.rw, tag: in_mem_req.tag};
        if (rsp_push) rsp_mem[rsp_wp] <= '{data: obi_rdata_i, tag: head.tag};
    end
endmodule
